hall_conditioner: RTL and testbench

//  Upstream stage of the BLDC commutation logic. Cleans raw Hall inputs H1..H3 with a synchroniser
//  and glitch filter, then decodes the rotor sector. Flags rotation direction and illegal codes or

---
 rtl/hall_pkg.sv | 38 +++
 rtl/hall_glitch_filter.sv | 51 +++++
 rtl/hall_conditioner.sv | 129 ++++++++++++
 tb/tb_hall_conditioner.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hall_pkg.sv
// Shared constants and decode helpers for the Hall sensor conditioner.
package hall_pkg;

    localparam logic [2:0] SECTOR_INVALID = 3'd7;
    localparam int         NUM_SECTORS    = 6;
    localparam logic [3:0] NUM_SECTORS_W  = 4'(NUM_SECTORS);

    // Classification of an accepted Hall code relative to the current sector
    typedef enum logic [1:0] {
        EV_NONE,
        EV_INIT,
        EV_STEP,
        EV_FAULT
    } accept_ev_e;

    // {H3,H2,H1} -> rotor sector; 000/111 are not produced by a healthy sensor set
    function automatic logic [2:0] sector_lut(input logic [2:0] code);
        case (code)
            3'b001:  return 3'd0;
            3'b101:  return 3'd1;
            3'b100:  return 3'd2;
            3'b110:  return 3'd3;
            3'b010:  return 3'd4;
            3'b011:  return 3'd5;
            default: return SECTOR_INVALID;
        endcase
    endfunction

    // (nw - old) mod 6 for legal sectors 0..5
    function automatic logic [2:0] delta6(input logic [2:0] nw, input logic [2:0] old);
        logic [3:0] d;
        d = {1'b0, nw} + NUM_SECTORS_W - {1'b0, old};
        if (d >= NUM_SECTORS_W)
            d = d - NUM_SECTORS_W;
        return d[2:0];
    endfunction

endpackage

// File: rtl/hall_glitch_filter.sv
// Two-flop synchroniser for the three Hall lines followed by a run-length filter;
// a code is accepted after FILT_CYCLES identical synced samples.
module hall_glitch_filter #(
    parameter int FILT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] raw,
    output logic [2:0] code,
    output logic       acc,
    output logic [2:0] acc_code
);

    localparam int            RW      = $clog2(FILT_CYCLES + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(FILT_CYCLES);
    localparam logic [RW-1:0] RUN_ACC = RW'(FILT_CYCLES - 1);

    logic [2:0]    s1, s2, cand;
    logic [RW-1:0] run;
    logic          first;

    // Strobe fires on the sample that brings the run to FILT_CYCLES, so the
    // owner can register the new code on the same edge as code.
    assign acc      = (s2 == cand) && (run == RUN_ACC) && ((cand != code) || first);
    assign acc_code = cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 3'b000;
            s2    <= 3'b000;
            cand  <= 3'b000;
            run   <= '0;
            first <= 1'b1;
            code  <= 3'b000;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                run  <= RW'(1);
            end else if (run != RUN_MAX) begin
                run <= run + 1'b1;
            end
            if (acc) begin
                code  <= cand;
                first <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hall_conditioner.sv
// Hall input conditioner: filtered code, sector decode, direction, fault and period.
// Optional HALL_FAULT_CLR_EN adds a FAULT_CLR input to clear the sticky fault.
module hall_conditioner
    import hall_pkg::*;
#(
    parameter int FILT_CYCLES = 8,
    parameter int PER_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             H1,
    input  logic             H2,
    input  logic             H3,
`ifdef HALL_FAULT_CLR_EN
    input  logic             FAULT_CLR,
`endif
    output logic [2:0]       HALL_Q,
    output logic [2:0]       SECTOR,
    output logic             STEP,
    output logic             DIR,
    output logic [PER_W-1:0] PERIOD,
    output logic             PER_VALID,
    output logic             STALL,
    output logic             FAULT
);

    localparam logic [PER_W-1:0] CNT_MAX = '1;

    logic             acc;
    logic [2:0]       acc_code;
    logic [2:0]       new_sec;
    logic             step_dir;
    logic             step_now;
    logic             fault_evt;
    logic             fault_clr;
    logic             armed;
    logic [PER_W-1:0] cnt;
    accept_ev_e       ev;

    hall_glitch_filter #(
        .FILT_CYCLES(FILT_CYCLES)
    ) u_filt (
        .clk     (CLK),
        .rst     (RST),
        .raw     ({H3, H2, H1}),
        .code    (HALL_Q),
        .acc     (acc),
        .acc_code(acc_code)
    );

`ifdef HALL_FAULT_CLR_EN
    assign fault_clr = FAULT_CLR;
`else
    assign fault_clr = 1'b0;
`endif

    // SECTOR==7 covers both the post-reset state and recovery after an illegal code
    always_comb begin
        ev       = EV_NONE;
        new_sec  = sector_lut(acc_code);
        step_dir = 1'b1;
        if (acc) begin
            if (new_sec == SECTOR_INVALID)
                ev = EV_FAULT;
            else if (SECTOR == SECTOR_INVALID)
                ev = EV_INIT;
            else begin
                case (delta6(new_sec, SECTOR))
                    3'd1:    ev = EV_STEP;
                    3'd5: begin
                        ev       = EV_STEP;
                        step_dir = 1'b0;
                    end
                    default: ev = EV_FAULT;
                endcase
            end
        end
    end

    assign step_now  = (ev == EV_STEP);
    assign fault_evt = (ev == EV_FAULT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            SECTOR    <= SECTOR_INVALID;
            STEP      <= 1'b0;
            DIR       <= 1'b1;
            PERIOD    <= '0;
            PER_VALID <= 1'b0;
            STALL     <= 1'b0;
            FAULT     <= 1'b0;
            cnt       <= '0;
            armed     <= 1'b0;
        end else begin
            STEP <= step_now;
            if (acc)
                SECTOR <= new_sec;
            if (step_now)
                DIR <= step_dir;

            if (fault_evt)
                FAULT <= 1'b1;
            else if (fault_clr)
                FAULT <= 1'b0;

            // A STEP in the saturating cycle still takes the measurement
            if (step_now) begin
                PERIOD <= cnt;
                cnt    <= {{(PER_W-1){1'b0}}, 1'b1};
                STALL  <= 1'b0;
                armed  <= 1'b1;
                if (armed)
                    PER_VALID <= 1'b1;
            end else if (cnt == CNT_MAX) begin
                STALL     <= 1'b1;
                PER_VALID <= 1'b0;
                armed     <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (fault_evt) begin
                PER_VALID <= 1'b0;
                armed     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hall_conditioner.sv
// Bench for hall_conditioner: table-driven rotation vectors, hand-written corner
// sequences and random Hall traffic against a cycle-level reference model.
module tb_hall_conditioner;

    localparam int F    = 8;
    localparam int PW   = 16;
    localparam int PMAX = (1 << PW) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic H1 = 1'b1, H2 = 1'b0, H3 = 1'b0;
`ifdef HALL_FAULT_CLR_EN
    logic FAULT_CLR = 1'b0;
`endif

    logic [2:0]    HALL_Q, SECTOR;
    logic          STEP, DIR, PER_VALID, STALL, FAULT;
    logic [PW-1:0] PERIOD;
    logic [2:0]    HALL_Q8, SECTOR8;
    logic          STEP8, DIR8, PER_VALID8, STALL8, FAULT8;
    logic [7:0]    PERIOD8;

    always #5 CLK = ~CLK;

    hall_conditioner #(.FILT_CYCLES(F), .PER_W(PW)) u_dut (
        .CLK(CLK), .RST(RST), .H1(H1), .H2(H2), .H3(H3),
`ifdef HALL_FAULT_CLR_EN
        .FAULT_CLR(FAULT_CLR),
`endif
        .HALL_Q(HALL_Q), .SECTOR(SECTOR), .STEP(STEP), .DIR(DIR), .PERIOD(PERIOD),
        .PER_VALID(PER_VALID), .STALL(STALL), .FAULT(FAULT)
    );

    hall_conditioner #(.FILT_CYCLES(F), .PER_W(8)) u_d8 (
        .CLK(CLK), .RST(RST), .H1(H1), .H2(H2), .H3(H3),
`ifdef HALL_FAULT_CLR_EN
        .FAULT_CLR(FAULT_CLR),
`endif
        .HALL_Q(HALL_Q8), .SECTOR(SECTOR8), .STEP(STEP8), .DIR(DIR8), .PERIOD(PERIOD8),
        .PER_VALID(PER_VALID8), .STALL(STALL8), .FAULT(FAULT8)
    );

    int nvec = 0, nerr = 0, nprint = 0;
    bit chk_en = 1'b0;
    int nstep = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c);
        {H3, H2, H1} = c;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // ---------------- reference model ----------------
    int         lut [8] = '{7, 0, 4, 5, 2, 1, 3, 7};
    int         fwd [6] = '{1, 5, 4, 6, 2, 3};
    int         cyc = 0, origin = 1, runlen = 0, mper = 0, msec = 7;
    logic [2:0] last_s = 3'd0, mq = 3'd0;
    bit         mfirst = 1, mstep = 0, mdir = 1, mpv = 0, mstall = 0, mfault = 0, marmed = 0;
    logic [2:0] rawq [$];

    always @(posedge CLK) begin : model_b
        logic [2:0] s;
        int ns, d, el;
        bit acc, stp, evt;
        cyc++;
        if (RST) begin
            rawq.delete();
            last_s = 3'd0; runlen = 0; mq = 3'd0; mfirst = 1; msec = 7;
            mstep = 0; mdir = 1; mper = 0; mpv = 0; mstall = 0; mfault = 0; marmed = 0;
            origin = cyc + 1;
        end else begin
            // filter sees the input as it was two edges ago; zeros right after reset
            rawq.push_back({H3, H2, H1});
            s = (rawq.size() >= 3) ? rawq[rawq.size() - 3] : 3'd0;
            if (rawq.size() > 3) void'(rawq.pop_front());
            if (s == last_s) runlen++; else runlen = 1;
            last_s = s;
            acc = (runlen == F) && ((s != mq) || mfirst);
            stp = 0; evt = 0;
            if (acc) begin
                mq = s; mfirst = 0; ns = lut[s];
                if (ns == 7) evt = 1;
                else if (msec != 7) begin
                    d = (ns + 6 - msec) % 6;
                    if (d == 1) begin stp = 1; mdir = 1; end
                    else if (d == 5) begin stp = 1; mdir = 0; end
                    else evt = 1;
                end
                msec = ns;
            end
            el = cyc - origin;
            if (stp) begin
                mper = (el < PMAX) ? el : PMAX;
                if (marmed) mpv = 1;
                marmed = 1; mstall = 0; origin = cyc;
            end else if (el >= PMAX) begin
                mstall = 1; mpv = 0; marmed = 0;
            end
            if (evt) begin mfault = 1; mpv = 0; marmed = 0; end
`ifdef HALL_FAULT_CLR_EN
            else if (FAULT_CLR) mfault = 0;
`endif
            mstep = stp;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            nvec++;
            if ({HALL_Q, SECTOR, STEP, DIR, PERIOD, PER_VALID, STALL, FAULT} !==
                {mq, 3'(msec), mstep, mdir, PW'(mper), mpv, mstall, mfault} ||
                {HALL_Q8, SECTOR8, STEP8, DIR8, FAULT8} !== {mq, 3'(msec), mstep, mdir, mfault}) begin
                nerr++;
                if (nprint < 10)
                    $display("FAIL model cyc %0d: got q=%b sec=%0d step=%b dir=%b per=%0d pv=%b stall=%b fault=%b (d8 q=%b sec=%0d step=%b dir=%b fault=%b), expected q=%b sec=%0d step=%b dir=%b per=%0d pv=%b stall=%b fault=%b",
                             cyc, HALL_Q, SECTOR, STEP, DIR, PERIOD, PER_VALID, STALL, FAULT,
                             HALL_Q8, SECTOR8, STEP8, DIR8, FAULT8,
                             mq, msec, mstep, mdir, mper, mpv, mstall, mfault);
                nprint++;
            end
        end
    end

    // counts STEP pulses one edge late so reads at negedge are race-free
    always @(posedge CLK) if (STEP === 1'b1) nstep++;

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] code;
        int         hold;
        int         sector;
        int         steps;
        bit         dir;
        bit         pv;
        int         period;   // -1: not checked
    } vec_t;

    vec_t tbl [13];

    initial begin
        int base, cur, r, hold;
        logic [2:0] g;

        tbl[0]  = '{3'b001, 1000, 0, 0, 1'b1, 1'b0, -1};
        tbl[1]  = '{3'b101, 1000, 1, 1, 1'b1, 1'b0, -1};
        tbl[2]  = '{3'b100, 1000, 2, 1, 1'b1, 1'b1, 1000};
        tbl[3]  = '{3'b110, 1000, 3, 1, 1'b1, 1'b1, 1000};
        tbl[4]  = '{3'b010, 1000, 4, 1, 1'b1, 1'b1, 1000};
        tbl[5]  = '{3'b011, 1000, 5, 1, 1'b1, 1'b1, 1000};
        tbl[6]  = '{3'b001, 1000, 0, 1, 1'b1, 1'b1, 1000};
        tbl[7]  = '{3'b011,  500, 5, 1, 1'b0, 1'b1, 1000};
        tbl[8]  = '{3'b010,  500, 4, 1, 1'b0, 1'b1, 500};
        tbl[9]  = '{3'b110,  500, 3, 1, 1'b0, 1'b1, 500};
        tbl[10] = '{3'b100,  500, 2, 1, 1'b0, 1'b1, 500};
        tbl[11] = '{3'b101,  500, 1, 1, 1'b0, 1'b1, 500};
        tbl[12] = '{3'b001,  500, 0, 1, 1'b0, 1'b1, 500};

        // reset state
        RST = 1'b1; drive(3'b001);
        wait_n(2);
        chk_en = 1'b1;
        chk("rst_hall_q", 32'(HALL_Q), 0);
        chk("rst_sector", 32'(SECTOR), 7);
        chk("rst_step", 32'(STEP), 0);
        chk("rst_dir", 32'(DIR), 1);
        chk("rst_period", 32'(PERIOD), 0);
        chk("rst_per_valid", 32'(PER_VALID), 0);
        chk("rst_stall", 32'(STALL), 0);
        chk("rst_fault", 32'(FAULT), 0);
        RST = 1'b0;

        // forward then reverse rotation
        for (int i = 0; i < 13; i++) begin
            base = nstep;
            drive(tbl[i].code);
            wait_n(tbl[i].hold);
            chk($sformatf("rot%0d_sector", i), 32'(SECTOR), tbl[i].sector);
            chk($sformatf("rot%0d_steps", i), nstep - base, tbl[i].steps);
            chk($sformatf("rot%0d_dir", i), 32'(DIR), 32'(tbl[i].dir));
            chk($sformatf("rot%0d_fault", i), 32'(FAULT), 0);
            chk($sformatf("rot%0d_per_valid", i), 32'(PER_VALID), 32'(tbl[i].pv));
            if (tbl[i].period >= 0)
                chk($sformatf("rot%0d_period", i), 32'(PERIOD), tbl[i].period);
        end

        // reset mid-rotation while a change is in flight
        drive(3'b011);
        wait_n(5);
        RST = 1'b1;
        wait_n(1);
        RST = 1'b0;
        chk("midrst_sector", 32'(SECTOR), 7);
        chk("midrst_dir", 32'(DIR), 1);
        chk("midrst_per_valid", 32'(PER_VALID), 0);
        chk("midrst_hall_q", 32'(HALL_Q), 0);
        base = nstep;
        wait_n(30);
        chk("midrst_first_sector", 32'(SECTOR), 5);
        chk("midrst_first_nostep", nstep - base, 0);

        // glitch one cycle short of acceptance
        RST = 1'b1; drive(3'b001); wait_n(1); RST = 1'b0;
        wait_n(30);
        base = nstep;
        drive(3'b101); wait_n(F - 1); drive(3'b001);
        wait_n(30);
        chk("glitch_sector", 32'(SECTOR), 0);
        chk("glitch_hall_q", 32'(HALL_Q), 1);
        chk("glitch_nostep", nstep - base, 0);

        // exact acceptance latency
        drive(3'b101);
        wait_n(F + 1);
        chk("lat_before_hall_q", 32'(HALL_Q), 1);
        chk("lat_before_step", 32'(STEP), 0);
        wait_n(1);
        chk("lat_hall_q", 32'(HALL_Q), 5);
        chk("lat_sector", 32'(SECTOR), 1);
        chk("lat_step", 32'(STEP), 1);
        wait_n(1);
        chk("lat_step_pulse", 32'(STEP), 0);
        wait_n(30);
        chk("lat_step_once", nstep - base, 1);

        // illegal code
        drive(3'b111);
        wait_n(30);
        chk("illegal_sector", 32'(SECTOR), 7);
        chk("illegal_fault", 32'(FAULT), 1);
        chk("illegal_per_valid", 32'(PER_VALID), 0);
`ifdef HALL_FAULT_CLR_EN
        drive(3'b101);
        wait_n(30);
        chk("fclr_held", 32'(FAULT), 1);
        FAULT_CLR = 1'b1; wait_n(1); FAULT_CLR = 1'b0;
        chk("fclr_clears", 32'(FAULT), 0);
        drive(3'b111);
        wait_n(F + 1);
        FAULT_CLR = 1'b1; wait_n(1); FAULT_CLR = 1'b0;
        chk("fclr_event_wins", 32'(FAULT), 1);
        wait_n(20);
`endif

        // non-adjacent jump
        RST = 1'b1; drive(3'b001); wait_n(1); RST = 1'b0;
        chk("skip_rst_fault", 32'(FAULT), 0);
        wait_n(30);
        base = nstep;
        drive(3'b100);
        wait_n(30);
        chk("skip_fault", 32'(FAULT), 1);
        chk("skip_sector", 32'(SECTOR), 2);
        chk("skip_nostep", nstep - base, 0);

        // stall on the 8-bit period instance
        RST = 1'b1; drive(3'b001); wait_n(1); RST = 1'b0;
        wait_n(300);
        chk("stall_set", 32'(STALL8), 1);
        chk("stall_per_valid", 32'(PER_VALID8), 0);
        drive(3'b101);
        wait_n(F + 2);
        chk("stall_step", 32'(STEP8), 1);
        chk("stall_cleared", 32'(STALL8), 0);
        chk("stall_pv_after_1st", 32'(PER_VALID8), 0);
        wait_n(100 - (F + 2));
        drive(3'b100);
        wait_n(F + 2);
        chk("stall_step2", 32'(STEP8), 1);
        chk("stall_pv_after_2nd", 32'(PER_VALID8), 1);
        chk("stall_period", 32'(PERIOD8), 100);
        wait_n(254);
        chk("stall_edge_before", 32'(STALL8), 0);
        wait_n(1);
        chk("stall_edge_at", 32'(STALL8), 1);
        chk("stall_edge_pv", 32'(PER_VALID8), 0);

        // random traffic; the per-cycle model comparison does the checking
        RST = 1'b1; drive(3'b001); wait_n(1); RST = 1'b0;
        wait_n(30);
        cur = 0;
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            hold = $urandom_range(3, 40);
            if (r < 5) begin
                cur = (cur + 1) % 6; drive(3'(fwd[cur]));
            end else if (r < 8) begin
                cur = (cur + 5) % 6; drive(3'(fwd[cur]));
            end else if (r == 8) begin
                g = 3'($urandom_range(0, 7));
                drive(g); wait_n($urandom_range(1, F - 1)); drive(3'(fwd[cur]));
            end else begin
                g = 3'($urandom_range(0, 7));
                drive(g);
                for (int j = 0; j < 6; j++) if (fwd[j] == int'(g)) cur = j;
            end
            wait_n(hold);
        end
        wait_n(20);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
